// File: rtl/bcd_converter_if.sv
// Binary-in / BCD-digits-out bundle for bcd_converter.
// Define BCD_HUNDREDS_EN to carry d100 instead of ovf.
interface bcd_converter_if #(
   parameter int IN_W  = 8,
   parameter int DIG_W = 4
);
   logic [IN_W-1:0]  hex;
   logic [DIG_W-1:0] d1;
   logic [DIG_W-1:0] d10;
`ifdef BCD_HUNDREDS_EN
   logic [1:0]       d100;
`else
   logic             ovf;
`endif

`ifdef BCD_HUNDREDS_EN
   modport master (output hex, input d1, d10, d100);
   modport slave  (input hex, output d1, d10, d100);
`else
   modport master (output hex, input d1, d10, ovf);
   modport slave  (input hex, output d1, d10, ovf);
`endif
endinterface

// File: rtl/bcd_converter.sv
// Registered 8-bit binary to BCD converter (double-dabble, one cycle latency).
// Macro BCD_HUNDREDS_EN: adds d100 output and drops the ovf flag.
module bcd_converter #(
   parameter int IN_W  = 8,
   parameter int DIG_W = 4
) (
   input  logic                 Clk,
   input  logic                 Rst,
   bcd_converter_if.slave       bus
);

   localparam int SR_W = 3 * DIG_W + IN_W;

   // stage[k] holds the shift register after k add-3/shift iterations
   logic [SR_W-1:0] stage [0:IN_W];

   assign stage[0] = {{(3 * DIG_W){1'b0}}, bus.hex};

   genvar gi;
   generate
      for (gi = 0; gi < IN_W; gi++) begin : g_dabble
         logic [SR_W-1:0] adj;

         always_comb begin
            adj = stage[gi];
            for (int n = 0; n < 3; n++) begin
               if (adj[IN_W + n * DIG_W +: DIG_W] >= DIG_W'(5)) begin
                  adj[IN_W + n * DIG_W +: DIG_W] = adj[IN_W + n * DIG_W +: DIG_W] + DIG_W'(3);
               end
            end
         end

         assign stage[gi + 1] = adj << 1;
      end
   endgenerate

   logic [DIG_W-1:0] d1_d,  d1_q;
   logic [DIG_W-1:0] d10_d, d10_q;

   assign d1_d  = stage[IN_W][IN_W +: DIG_W];
   assign d10_d = stage[IN_W][IN_W + DIG_W +: DIG_W];

`ifdef BCD_HUNDREDS_EN
   logic [1:0] d100_d, d100_q;

   assign d100_d = stage[IN_W][IN_W + 2 * DIG_W +: 2];

   always_ff @(posedge Clk) begin
      if (Rst) begin
         d1_q   <= '0;
         d10_q  <= '0;
         d100_q <= '0;
      end else begin
         d1_q   <= d1_d;
         d10_q  <= d10_d;
         d100_q <= d100_d;
      end
   end

   assign bus.d100 = d100_q;
`else
   logic ovf_d, ovf_q;

   // A non-zero hundreds digit is exactly the >99 condition; tens/ones wrap mod 100.
   assign ovf_d = |stage[IN_W][IN_W + 2 * DIG_W +: DIG_W];

   always_ff @(posedge Clk) begin
      if (Rst) begin
         d1_q  <= '0;
         d10_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         d1_q  <= d1_d;
         d10_q <= d10_d;
         ovf_q <= ovf_d;
      end
   end

   assign bus.ovf = ovf_q;
`endif

   assign bus.d1  = d1_q;
   assign bus.d10 = d10_q;

endmodule

// File: tb/tb_bcd_converter.sv
// Scoreboard bench for bcd_converter; follows BCD_HUNDREDS_EN like the design.
module tb_bcd_converter;

   logic Clk = 1'b0;
   logic Rst;

   always #5 Clk = ~Clk;

   bcd_converter_if bus ();

   bcd_converter dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   typedef struct {
      logic [7:0] hex;
      logic       rst;
      logic [3:0] d1;
      logic [3:0] d10;
      logic [1:0] d100;
      logic       ovf;
   } exp_t;

   exp_t sb [$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic compare_out();
      exp_t e;
      e = sb.pop_front();
      check("d1",       32'(bus.d1),  32'(e.d1));
      check("d10",      32'(bus.d10), 32'(e.d10));
      check("d1_bcd",   32'(bus.d1  <= 4'd9), 32'd1);
      check("d10_bcd",  32'(bus.d10 <= 4'd9), 32'd1);
`ifdef BCD_HUNDREDS_EN
      check("d100",     32'(bus.d100), 32'(e.d100));
      $display("txn hex=%0d rst=%0b -> d100=%0d d10=%0d d1=%0d (exp %0d %0d %0d)",
               e.hex, e.rst, bus.d100, bus.d10, bus.d1, e.d100, e.d10, e.d1);
`else
      check("ovf",      32'(bus.ovf), 32'(e.ovf));
      $display("txn hex=%0d rst=%0b -> ovf=%0b d10=%0d d1=%0d (exp %0b %0d %0d)",
               e.hex, e.rst, bus.ovf, bus.d10, bus.d1, e.ovf, e.d10, e.d1);
`endif
   endtask

   // One clock: check what the previous edge produced, then drive the next input.
   task automatic cycle(input logic rst, input logic [7:0] h);
      exp_t e;
      @(negedge Clk);
      if (sb.size() > 0) compare_out();
      Rst     = rst;
      bus.hex = h;
      e.hex   = h;
      e.rst   = rst;
      if (rst) begin
         e.d1 = 4'd0; e.d10 = 4'd0; e.d100 = 2'd0; e.ovf = 1'b0;
      end else begin
         e.d1   = 4'(h % 10);
         e.d10  = 4'((h % 100) / 10);
         e.d100 = 2'(h / 100);
         e.ovf  = (h > 8'd99);
      end
      sb.push_back(e);
   endtask

   initial begin
      Rst     = 1'b1;
      bus.hex = 8'h63;

      // reset with a live input, then release
      cycle(1'b1, 8'h63);
      cycle(1'b1, 8'h63);
      cycle(1'b0, 8'h63);

      // representative in-range values
      cycle(1'b0, 8'h45);
      cycle(1'b0, 8'h63);
      cycle(1'b0, 8'h08);
      cycle(1'b0, 8'h00);
      cycle(1'b0, 8'h4D);

      // boundaries
      cycle(1'b0, 8'h64);
      cycle(1'b0, 8'hFF);
      cycle(1'b0, 8'd99);

      // reset pulse in a changing stream
      for (int i = 0; i < 8; i++) begin
         cycle(i == 4, 8'(8'd37 + i * 29));
      end

      // exhaustive sweep
      for (int v = 0; v < 256; v++) begin
         cycle(1'b0, 8'(v));
      end

      // random back-to-back values with occasional reset
      for (int i = 0; i < 40; i++) begin
         cycle(($urandom_range(0, 15) == 0), 8'($urandom_range(0, 255)));
      end

      @(negedge Clk);
      if (sb.size() > 0) compare_out();
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
